i2c_mst_sched: RTL and testbench

Round-robin scheduler that shares one `i2c_master` between `NREQ` requesters. It accepts one transaction descriptor at a time: target address, direction, length and a 128-bit write payload. It drives the master's `mst_ctrl`/`mst_wfifo` inputs, tracks `mst_status` busy, and returns read data plus a completion status to the winning requester. It sits between the register/host side and the I2C master in the same clock domain.

---
 rtl/i2c_mst_sched.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_mst_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mst_sched.sv
// Round-robin scheduler sharing one I2C master between NREQ requesters.
// One descriptor in flight at a time: grant, launch, wait for busy to drop, respond.
module i2c_mst_sched #(
    parameter int NREQ      = 4,
    parameter int LAUNCH_TO = 64,
    parameter int XFER_TO   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [7*NREQ-1:0]    req_addr,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [4*NREQ-1:0]    req_len,
    input  logic [128*NREQ-1:0]  req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [1:0]           rsp_err,
    output logic [127:0]         rsp_rdata,
    output logic                 sched_busy,
    output logic [15:0]          mst_ctrl,
    output logic [127:0]         mst_wfifo,
    input  logic [127:0]         mst_rfifo,
    input  logic [7:0]           mst_status
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [15:0]     LAUNCH_LAST = 16'(LAUNCH_TO - 1);
    localparam logic [15:0]     XFER_LAST   = 16'(XFER_TO - 1);
    localparam logic [NREQ-1:0] ONE_HOT0    = {{(NREQ-1){1'b0}}, 1'b1};

    state_t         state_r;
    logic [2:0]     rr_ptr_r;
    logic [15:0]    cnt_r;
    logic [2:0]     rsp_id_r;
    logic [1:0]     rsp_err_r;
    logic [127:0]   rsp_rdata_r;
    logic           rsp_valid_r;
    logic           sched_busy_r;
    logic [15:0]    mst_ctrl_r;
    logic [127:0]   mst_wfifo_r;

    logic [7:0]     valid8_s;
    logic [3:0]     cand_s;
    logic           grant_hit_s;
    logic [2:0]     grant_idx_s;
    logic [6:0]     sel_addr_s;
    logic           sel_rw_s;
    logic [3:0]     sel_len_s;
    logic [127:0]   sel_wdata_s;
    logic           busy_s;
    logic           status_unused_s;

    assign valid8_s        = 8'(req_valid);
    assign busy_s          = mst_status[7];
    assign status_unused_s = ^mst_status[6:0];

    // Winner search: first valid requester at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        grant_hit_s = 1'b0;
        grant_idx_s = 3'd0;
        cand_s      = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, rr_ptr_r} + 4'(k);
            if (cand_s >= 4'(NREQ)) begin
                cand_s = cand_s - 4'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_hit_s && valid8_s[cand_s[2:0]]) begin
                grant_hit_s = 1'b1;
                grant_idx_s = cand_s[2:0];
            end else begin
                grant_hit_s = grant_hit_s;
            end
        end
    end

    // Descriptor mux for the current winner.
    always_comb begin
        sel_addr_s  = 7'd0;
        sel_rw_s    = 1'b0;
        sel_len_s   = 4'd0;
        sel_wdata_s = 128'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == 3'(i)) begin
                sel_addr_s  = req_addr[7*i +: 7];
                sel_rw_s    = req_rw[i];
                sel_len_s   = req_len[4*i +: 4];
                sel_wdata_s = req_wdata[128*i +: 128];
            end else begin
                sel_addr_s  = sel_addr_s;
                sel_rw_s    = sel_rw_s;
                sel_len_s   = sel_len_s;
                sel_wdata_s = sel_wdata_s;
            end
        end
    end

    // Acceptance pulse is combinational so the requester sees it in the grant cycle.
    always_comb begin
        if (state_r == IDLE && grant_hit_s && !rst) begin
            req_ready = ONE_HOT0 << grant_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    // Scheduler FSM with registered master-side and response-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rr_ptr_r     <= 3'd0;
            cnt_r        <= 16'd0;
            rsp_id_r     <= 3'd0;
            rsp_err_r    <= 2'b00;
            rsp_rdata_r  <= 128'd0;
            rsp_valid_r  <= 1'b0;
            sched_busy_r <= 1'b0;
            mst_ctrl_r   <= 16'd0;
            mst_wfifo_r  <= 128'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_hit_s) begin
                        rsp_id_r     <= grant_idx_s;
                        rr_ptr_r     <= (grant_idx_s == 3'(NREQ - 1)) ? 3'd0 : grant_idx_s + 3'd1;
                        cnt_r        <= 16'd0;
                        sched_busy_r <= 1'b1;
                        mst_ctrl_r   <= {sel_addr_s, sel_rw_s, 1'b1, 3'b000, sel_len_s};
                        mst_wfifo_r  <= sel_wdata_s;
                        state_r      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (busy_s) begin
                        mst_ctrl_r[7] <= 1'b0;
                        cnt_r         <= 16'd0;
                        state_r       <= WAIT_DONE;
                    end else if (cnt_r == LAUNCH_LAST) begin
                        rsp_err_r   <= 2'b01;
                        rsp_rdata_r <= 128'd0;
                        rsp_valid_r <= 1'b1;
                        mst_ctrl_r  <= 16'd0;
                        mst_wfifo_r <= 128'd0;
                        cnt_r       <= 16'd0;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    // Timeout leaves the master running; it is not aborted from here.
                    if (!busy_s) begin
                        rsp_err_r   <= 2'b00;
                        rsp_rdata_r <= mst_rfifo;
                        rsp_valid_r <= 1'b1;
                        mst_ctrl_r  <= 16'd0;
                        mst_wfifo_r <= 128'd0;
                        cnt_r       <= 16'd0;
                        state_r     <= RESP;
                    end else if (cnt_r == XFER_LAST) begin
                        rsp_err_r   <= 2'b10;
                        rsp_rdata_r <= 128'd0;
                        rsp_valid_r <= 1'b1;
                        mst_ctrl_r  <= 16'd0;
                        mst_wfifo_r <= 128'd0;
                        cnt_r       <= 16'd0;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r  <= 1'b0;
                        sched_busy_r <= 1'b0;
                        rsp_id_r     <= 3'd0;
                        rsp_err_r    <= 2'b00;
                        rsp_rdata_r  <= 128'd0;
                        cnt_r        <= 16'd0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // pld_rdy is masked while reset is held so the master never sees a stale launch.
    assign mst_ctrl   = mst_ctrl_r & {8'hFF, ~rst, 7'h7F};
    assign mst_wfifo  = mst_wfifo_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_err    = rsp_err_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign sched_busy = sched_busy_r;

endmodule

// File: tb/tb_i2c_mst_sched.sv
// Directed bench for i2c_mst_sched: transaction-level reference model plus
// a behavioural I2C master whose busy timing is set per transaction.
module tb_i2c_mst_sched;

    localparam int NREQ      = 4;
    localparam int LAUNCH_TO = 64;
    localparam int XFER_TO   = 100;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [7*NREQ-1:0]    req_addr;
    logic [NREQ-1:0]      req_rw;
    logic [4*NREQ-1:0]    req_len;
    logic [128*NREQ-1:0]  req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2:0]           rsp_id;
    logic [1:0]           rsp_err;
    logic [127:0]         rsp_rdata;
    logic                 sched_busy;
    logic [15:0]          mst_ctrl;
    logic [127:0]         mst_wfifo;
    logic [127:0]         mst_rfifo;
    logic [7:0]           mst_status;

    i2c_mst_sched #(.NREQ(NREQ), .LAUNCH_TO(LAUNCH_TO), .XFER_TO(XFER_TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_rw(req_rw),
        .req_len(req_len), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .sched_busy(sched_busy),
        .mst_ctrl(mst_ctrl), .mst_wfifo(mst_wfifo),
        .mst_rfifo(mst_rfifo), .mst_status(mst_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference model: phase 0 idle, 1 launched, 2 master busy, 3 response pending.
    int           m_phase = 0;
    int           m_cyc   = 0;
    int           m_ptr   = 0;
    int           m_g     = 0;
    logic [6:0]   m_addr  = '0;
    logic         m_rw    = 1'b0;
    logic [3:0]   m_len   = '0;
    logic [127:0] m_wdata = '0;
    logic [127:0] m_rdata = '0;
    logic [1:0]   m_err   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_cyc   <= 0;
        end else if (m_phase == 0) begin
            if (req_valid != '0) begin
                m_g     <= pick(req_valid, m_ptr);
                m_ptr   <= (pick(req_valid, m_ptr) + 1) % NREQ;
                m_addr  <= req_addr[7*pick(req_valid, m_ptr) +: 7];
                m_rw    <= req_rw[pick(req_valid, m_ptr)];
                m_len   <= req_len[4*pick(req_valid, m_ptr) +: 4];
                m_wdata <= req_wdata[128*pick(req_valid, m_ptr) +: 128];
                m_phase <= 1;
                m_cyc   <= 0;
            end
        end else if (m_phase == 1) begin
            if (mst_status[7]) begin
                m_phase <= 2;
                m_cyc   <= 0;
            end else if (m_cyc == LAUNCH_TO - 1) begin
                m_err <= 2'b01; m_rdata <= '0; m_phase <= 3;
            end else m_cyc <= m_cyc + 1;
        end else if (m_phase == 2) begin
            if (!mst_status[7]) begin
                m_err <= 2'b00; m_rdata <= mst_rfifo; m_phase <= 3;
            end else if (m_cyc == XFER_TO - 1) begin
                m_err <= 2'b10; m_rdata <= '0; m_phase <= 3;
            end else m_cyc <= m_cyc + 1;
        end else if (rsp_ready) begin
            m_phase <= 0;
        end
    end

    function automatic logic [NREQ-1:0] exp_ready();
        if (m_phase == 0 && pick(req_valid, m_ptr) >= 0)
            return {{(NREQ-1){1'b0}}, 1'b1} << pick(req_valid, m_ptr);
        return '0;
    endfunction

    function automatic logic [15:0] exp_ctrl();
        if (m_phase == 1) return {m_addr, m_rw, 1'b1, 3'b000, m_len};
        if (m_phase == 2) return {m_addr, m_rw, 1'b0, 3'b000, m_len};
        return 16'h0000;
    endfunction

    // Monitor-side bookkeeping for the directed checks.
    int           grant_q[$];
    int           ready_cnt[NREQ];
    int           pld_cycles = 0;
    logic [15:0]  last_launch_ctrl = '0;
    logic [15:0]  last_wait_ctrl   = '0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("req_ready", req_ready, exp_ready());
            check("mst_ctrl", mst_ctrl, exp_ctrl());
            check("mst_wfifo", mst_wfifo, (m_phase == 1 || m_phase == 2) ? m_wdata : 128'h0);
            check("sched_busy", sched_busy, m_phase != 0);
            check("rsp_valid", rsp_valid, m_phase == 3);
            if (m_phase == 3) begin
                check("rsp_id", rsp_id, m_g);
                check("rsp_err", rsp_err, m_err);
                check("rsp_rdata", rsp_rdata, m_rdata);
            end
            for (int k = 0; k < NREQ; k++) begin
                if (req_ready[k]) begin
                    grant_q.push_back(k);
                    ready_cnt[k]++;
                end
            end
            if (mst_ctrl[7]) begin
                pld_cycles++;
                last_launch_ctrl = mst_ctrl;
            end else if (mst_ctrl != 16'h0000) begin
                last_wait_ctrl = mst_ctrl;
            end
        end
    end

    // Behavioural master: busy rises mm_rise cycles after it sees pld_rdy and
    // falls mm_hold cycles later (negative value = never).
    int           mm_rise = 2;
    int           mm_hold = 5;
    logic [127:0] mm_rdata = '0;
    int           mm_st = 0;
    int           mm_cnt = 0;

    initial begin
        mst_status = 8'h0C;
        mst_rfifo  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                mm_st = 0;
                mst_status = 8'h0C;
            end else if (mm_st == 0) begin
                if (mst_ctrl[7] && mm_rise >= 0) begin mm_st = 1; mm_cnt = 0; end
            end else if (mm_st == 1) begin
                mm_cnt++;
                if (mm_cnt >= mm_rise) begin mst_status = 8'h93; mm_st = 2; mm_cnt = 0; end
            end else begin
                mm_cnt++;
                if (mm_hold >= 0 && mm_cnt >= mm_hold) begin
                    mst_status = 8'h0C;
                    mst_rfifo  = mm_rdata;
                    mm_st = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic rw,
                           input logic [3:0] len, input logic [127:0] wd);
        req_addr[7*i +: 7]      = a;
        req_rw[i]               = rw;
        req_len[4*i +: 4]       = len;
        req_wdata[128*i +: 128] = wd;
    endtask

    task automatic wait_rsp(input string name, input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (rsp_valid) return;
        end
        check(name, rsp_valid, 1'b1);
    endtask

    task automatic ack();
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Single request from requester i; returns at the first response cycle (negedge).
    task automatic run_txn(input int i, input logic [6:0] a, input logic rw, input logic [3:0] len,
                           input logic [127:0] wd, input int rise, input int hold,
                           input logic [127:0] rd, input string name);
        mm_rise = rise; mm_hold = hold; mm_rdata = rd;
        set_req(i, a, rw, len, wd);
        pld_cycles = 0;
        for (int k = 0; k < NREQ; k++) ready_cnt[k] = 0;
        rsp_ready = 1'b0;
        req_valid = {{(NREQ-1){1'b0}}, 1'b1} << i;
        tick();
        req_valid = '0;
        req_addr[7*i +: 7] = ~a;
        wait_rsp(name, 400);
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_rw = '0; req_len = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", req_ready, 4'b0000);
        check("reset_ctrl", mst_ctrl, 16'h0000);
        check("reset_wfifo", mst_wfifo, 128'h0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_busy", sched_busy, 1'b0);
        check("reset_rdata", rsp_rdata, 128'h0);

        // Round robin with every requester asserting and responses consumed at once.
        mm_rise = 1; mm_hold = 3; mm_rdata = 128'h77;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 7'(7'h10 + i), i[0], 4'(i), {4{32'(i * 32'h01010101)}});
        tick();
        grant_q.delete();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int t = 0; t < 300 && grant_q.size() < 5; t++) tick();
        req_valid = '0;
        check("rr_grant_count", grant_q.size() >= 5, 1'b1);
        for (int k = 0; k < 5 && k < grant_q.size(); k++) check("rr_order", grant_q[k], exp_order[k]);
        for (int t = 0; t < 100 && sched_busy; t++) tick();
        rsp_ready = 1'b0;

        // Single write; busy falls on the last allowed WAIT_DONE cycle, so completion wins.
        run_txn(1, 7'h50, 1'b0, 4'd1, {16'hA55A, 112'h0}, 2, 100, 128'h1234, "write_rsp");
        check("write_id", rsp_id, 3'd1);
        check("write_err", rsp_err, 2'b00);
        check("write_launch_ctrl", last_launch_ctrl, 16'hA081);
        check("write_wait_ctrl", last_wait_ctrl, 16'hA001);
        check("write_ready_pulses", ready_cnt[1], 1);
        ack();

        // Read; busy arrives on the last allowed LAUNCH cycle.
        run_txn(0, 7'h3C, 1'b1, 4'd0, 128'h0, 63, 4, {8'h5A, 120'h0}, "read_rsp");
        check("read_rdata", rsp_rdata, {8'h5A, 120'h0});
        check("read_err", rsp_err, 2'b00);
        check("read_launch_cycles", pld_cycles, 64);
        ack();

        // Launch timeout: master never goes busy.
        run_txn(3, 7'h22, 1'b0, 4'd15, {4{32'hCAFE_F00D}}, -1, 0, 128'h0, "lto_rsp");
        check("lto_err", rsp_err, 2'b01);
        check("lto_launch_cycles", pld_cycles, 64);
        check("lto_ctrl", mst_ctrl, 16'h0000);
        check("lto_id", rsp_id, 3'd3);
        ack();

        // Transfer timeout with busy stuck; response held 5 cycles, no grant meanwhile.
        run_txn(2, 7'h11, 1'b1, 4'd3, 128'h0, 1, -1, 128'hDEAD, "xto_rsp");
        check("xto_err", rsp_err, 2'b10);
        check("xto_rdata", rsp_rdata, 128'h0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 2) req_valid = 4'hF;
            if (c == 5) rsp_ready = 1'b1;
            @(negedge clk);
            check("xto_hold_valid", rsp_valid, 1'b1);
            check("xto_no_grant", req_ready, 4'b0000);
        end
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("xto_next_grant", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("wait_ctrl_req3", mst_ctrl, 16'hBA0F);

        // Reset while in WAIT_DONE, then rr_ptr must be back at 0.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ctrl", mst_ctrl, 16'h0000);
        check("rst_mid_wfifo", mst_wfifo, 128'h0);
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check("rst_mid_busy", sched_busy, 1'b0);
        check("rst_mid_err", rsp_err, 2'b00);
        mm_rise = 1; mm_hold = 2; mm_rdata = 128'h9;
        tick();
        req_valid = 4'b0110;
        @(negedge clk);
        check("rst_rr_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_rsp("post_rst_rsp", 400);
        check("post_rst_id", rsp_id, 3'd1);
        ack();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
